// File: rtl/snn_pkg.sv
// Shared types and default sizing for the SNN core event path.
package snn_pkg;

    localparam int ADDR_W_DEF    = 4;
    localparam int ISSUE_GAP_DEF = 18;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/evt_fifo.sv
// Pending-event FIFO for the spike arbiter. With EVT_COALESCE_EN defined it also
// exposes every slot address plus a per-slot valid flag for duplicate detection.
module evt_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
`ifdef EVT_COALESCE_EN
    ,
    output logic [DEPTH*WIDTH-1:0] entry_addr_o,
    output logic [DEPTH-1:0]       entry_valid_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef EVT_COALESCE_EN
    // A slot is live when its distance past the read pointer is below the occupancy.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [PTR_W-1:0] offset;
        assign offset = PTR_W'(gi) - rd_ptr_q;
        assign entry_valid_o[gi] = (CNT_W'(offset) < count_q);
        assign entry_addr_o[gi*WIDTH +: WIDTH] = mem_q[gi];
    end
`endif

endmodule

// File: rtl/spike_event_arbiter.sv
// Round-robin spike event arbiter with a paced issue FSM toward the weight controller.
// Optional duplicate-event coalescing is enabled by defining EVT_COALESCE_EN.
module spike_event_arbiter
    import snn_pkg::*;
#(
    parameter int NUM_SRC    = 16,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int FIFO_DEPTH = 8,
    parameter int ISSUE_GAP  = ISSUE_GAP_DEF
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_SRC-1:0]            src_req,
    output logic [NUM_SRC-1:0]            src_ack,
    input  logic                          hold,
    output logic [ADDR_W-1:0]             event_addr,
    output logic                          event_received,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    coalesce_cnt
);

    localparam int GAP_W = $clog2(ISSUE_GAP) + 1;

    arb_state_t        state_q, state_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [ADDR_W-1:0] event_addr_q;
    logic [ADDR_W-1:0] rr_ptr_q;
    logic [ADDR_W-1:0] grant_idx, cand;
    logic              grant_found, grant_valid;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ADDR_W-1:0] fifo_head;

    // First requester at or after rr_ptr; the address width wraps the search.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand = rr_ptr_q + ADDR_W'(i);
            if (!grant_found && src_req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign grant_valid = grant_found && !fifo_full && reset_n;
    assign src_ack     = grant_valid ? (NUM_SRC'(1) << grant_idx) : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
        end else if (grant_valid) begin
            rr_ptr_q <= grant_idx + 1'b1;
        end
    end

`ifdef EVT_COALESCE_EN
    logic [FIFO_DEPTH*ADDR_W-1:0] entry_addr;
    logic [FIFO_DEPTH-1:0]        entry_valid;
    logic                         addr_match;
    logic [7:0]                   coalesce_q;

    always_comb begin
        addr_match = 1'b0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            if (entry_valid[k] && entry_addr[k*ADDR_W +: ADDR_W] == grant_idx) begin
                addr_match = 1'b1;
            end
        end
    end

    assign fifo_push = grant_valid && !addr_match;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            coalesce_q <= '0;
        end else if (grant_valid && addr_match && coalesce_q != 8'hFF) begin
            coalesce_q <= coalesce_q + 1'b1;
        end
    end

    assign coalesce_cnt = coalesce_q;
`else
    assign fifo_push    = grant_valid;
    assign coalesce_cnt = 8'h00;
`endif

    evt_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i        (clock),
        .rst_ni       (reset_n),
        .push_i       (fifo_push),
        .push_data_i  (grant_idx),
        .pop_i        (fifo_pop),
        .head_o       (fifo_head),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .count_o      (fifo_count)
`ifdef EVT_COALESCE_EN
        ,
        .entry_addr_o (entry_addr),
        .entry_valid_o(entry_valid)
`endif
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            gap_cnt_q    <= '0;
            event_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            if (fifo_pop) begin
                event_addr_q <= fifo_head;
            end
        end
    end

    // GAP lasts ISSUE_GAP-2 cycles so that, with one IDLE pop cycle, pulses land ISSUE_GAP apart.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !hold) state_d = ISSUE;
            end
            ISSUE: begin
                gap_cnt_d = GAP_W'(ISSUE_GAP - 2);
                state_d   = (ISSUE_GAP > 2) ? GAP : IDLE;
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q - 1'b1;
                if (gap_cnt_q <= GAP_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_pop       = (state_q == IDLE) && !fifo_empty && !hold;
        event_received = (state_q == ISSUE);
        event_addr     = event_addr_q;
    end

endmodule
